rocfifo_merge_cntrl: RTL and testbench

//  Parametrised N-channel merger from FWFT ROCFIFOs into the EW_FIFO pair feeding DDR readout. Per event window,

---
 rtl/rocfifo_merge_cntrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_rocfifo_merge_cntrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rocfifo_merge_cntrl.sv
// Merges one header+payload per enabled ROCFIFO channel into the EW_FIFO, in ascending channel order.
// Tracks EW size/tag/status and pads channels abandoned by the empty-timeout.
module rocfifo_merge_cntrl #(
    parameter int NROCFIFO   = 4,
    parameter int DIGI_BITS  = 32,
    parameter int TAG_BITS   = 20,
    parameter int MAX_BEATS  = 1020,
    parameter int TIMEOUT    = 4096,
    parameter int RESET_WAIT = 240
) (
    input  logic                          serdesclk,
    input  logic                          resetn_serdesclk,
    input  logic [NROCFIFO-1:0]           rocfifo_empty,
    input  logic [NROCFIFO*DIGI_BITS-1:0] rocfifo_data,
    output logic [NROCFIFO-1:0]           rocfifo_re,
    input  logic [NROCFIFO-1:0]           ch_enable,
    input  logic                          ew_fifo_full,
    input  logic                          axi_start_on_serdesclk,
    output logic                          curr_ewfifo_wr,
    output logic                          ew_fifo_we,
    output logic [DIGI_BITS-1:0]          ew_data,
    output logic                          ew_done,
    output logic [11:0]                   ew_size,
    output logic [TAG_BITS-1:0]           ew_tag,
    output logic                          ew_ovfl,
    output logic                          ew_tag_error,
    output logic                          ew_timeout,
    output logic [NROCFIFO-1:0]           ew_ch_missing
);
    localparam int IW = (NROCFIFO > 1) ? $clog2(NROCFIFO) : 1;
    localparam int SW = DIGI_BITS - TAG_BITS;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = (RESET_WAIT > 1) ? $clog2(RESET_WAIT + 1) : 1;
    localparam logic [15:0] FWD_LIMIT = 16'(2 * MAX_BEATS);
    localparam logic [15:0] MAXB      = 16'(MAX_BEATS);

    typedef enum logic [2:0] {
        S_RESET, S_IDLE, S_HEADER, S_PAYLOAD, S_PAD, S_NEXT, S_HOLD
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [RW-1:0]         r_rst_cnt;
    logic [NROCFIFO-1:0]   r_en;
    logic [IW-1:0]         r_idx;
    logic [15:0]           r_acc, r_rem, r_fwd;
    logic [TW-1:0]         r_tmo;
    logic                  r_first;
    logic                  r_curr, r_we, r_done, r_ovfl, r_tag_err, r_timeout;
    logic [DIGI_BITS-1:0]  r_data;
    logic [11:0]           r_size;
    logic [TAG_BITS-1:0]   r_tag;
    logic [NROCFIFO-1:0]   r_missing;

    logic [DIGI_BITS-1:0]  w_cur_data;
    logic                  w_cur_empty;
    logic [NROCFIFO-1:0]   w_idx_oh;
    logic                  w_active, w_rd, w_tmo_hit, w_fwd_ok, w_start;
    logic                  w_first_vld, w_first_empty, w_next_vld;
    logic [IW-1:0]         w_first_idx, w_next_idx;
    logic [SW-1:0]         w_hdr_size;
    logic [TAG_BITS-1:0]   w_hdr_tag;
    logic [15:0]           w_beats;

    // Current-channel mux and one-hot select
    always_comb begin
        w_cur_data  = '0;
        w_cur_empty = 1'b1;
        w_idx_oh    = '0;
        for (int i = 0; i < NROCFIFO; i++) begin
            if (r_idx == IW'(i)) begin
                w_cur_data  = rocfifo_data[i*DIGI_BITS +: DIGI_BITS];
                w_cur_empty = rocfifo_empty[i];
                w_idx_oh[i] = 1'b1;
            end
        end
    end

    // Descending scan so the lowest qualifying index wins
    always_comb begin
        w_first_vld   = 1'b0;
        w_first_idx   = '0;
        w_first_empty = 1'b1;
        w_next_vld    = 1'b0;
        w_next_idx    = '0;
        for (int i = NROCFIFO - 1; i >= 0; i--) begin
            if (ch_enable[i]) begin
                w_first_vld   = 1'b1;
                w_first_idx   = IW'(i);
                w_first_empty = rocfifo_empty[i];
            end
            if (r_en[i] && (IW'(i) > r_idx)) begin
                w_next_vld = 1'b1;
                w_next_idx = IW'(i);
            end
        end
    end

    assign w_active   = (r_state == S_HEADER) || (r_state == S_PAYLOAD);
    assign w_rd       = w_active && !w_cur_empty && !ew_fifo_full;
    assign w_tmo_hit  = w_active && w_cur_empty && !ew_fifo_full && (r_tmo == TW'(TIMEOUT - 1));
    assign w_fwd_ok   = (r_fwd < FWD_LIMIT);
    assign w_start    = w_first_vld && !w_first_empty;
    assign w_hdr_size = w_cur_data[DIGI_BITS-1:TAG_BITS];
    assign w_hdr_tag  = w_cur_data[TAG_BITS-1:0];
    assign w_beats    = {1'b0, r_acc[15:1]};
    assign rocfifo_re = w_idx_oh & {NROCFIFO{w_rd}};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RESET:   if (int'(r_rst_cnt) >= RESET_WAIT - 1) w_state_nxt = S_IDLE;
            S_IDLE:    if (w_start) w_state_nxt = S_HEADER;
            S_HEADER: begin
                if (w_rd)           w_state_nxt = (w_hdr_size == '0) ? S_NEXT : S_PAYLOAD;
                else if (w_tmo_hit) w_state_nxt = S_NEXT;
            end
            S_PAYLOAD: begin
                if (w_rd && r_rem == 16'd1) w_state_nxt = S_NEXT;
                else if (w_tmo_hit)         w_state_nxt = S_PAD;
            end
            S_PAD:     if (!ew_fifo_full && r_rem == 16'd1) w_state_nxt = S_NEXT;
            S_NEXT:    w_state_nxt = w_next_vld ? S_HEADER : S_HOLD;
            S_HOLD:    if (axi_start_on_serdesclk) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_RESET;
        endcase
    end

    always_ff @(posedge serdesclk or negedge resetn_serdesclk) begin
        if (!resetn_serdesclk) r_state <= S_RESET;
        else                   r_state <= w_state_nxt;
    end

    always_ff @(posedge serdesclk or negedge resetn_serdesclk) begin
        if (!resetn_serdesclk) begin
            r_rst_cnt <= '0;
            r_en      <= '0;
            r_idx     <= '0;
            r_acc     <= '0;
            r_rem     <= '0;
            r_fwd     <= '0;
            r_tmo     <= '0;
            r_first   <= 1'b0;
            r_curr    <= 1'b1;
            r_we      <= 1'b0;
            r_done    <= 1'b0;
            r_data    <= '0;
            r_size    <= '0;
            r_tag     <= '0;
            r_ovfl    <= 1'b0;
            r_tag_err <= 1'b0;
            r_timeout <= 1'b0;
            r_missing <= '0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            // Empty-cycle counter; frozen while the EW_FIFO is full
            if (w_active) begin
                if (w_rd || w_tmo_hit)              r_tmo <= '0;
                else if (!ew_fifo_full && w_cur_empty) r_tmo <= r_tmo + 1'b1;
                if (w_tmo_hit) begin
                    r_timeout <= 1'b1;
                    r_missing <= r_missing | w_idx_oh;
                end
            end
            case (r_state)
                S_RESET: r_rst_cnt <= r_rst_cnt + 1'b1;
                S_IDLE: begin
                    if (w_start) begin
                        r_en      <= ch_enable;
                        r_idx     <= w_first_idx;
                        r_curr    <= ~r_curr;
                        r_acc     <= '0;
                        r_fwd     <= '0;
                        r_tmo     <= '0;
                        r_first   <= 1'b1;
                        r_size    <= '0;
                        r_ovfl    <= 1'b0;
                        r_tag_err <= 1'b0;
                        r_timeout <= 1'b0;
                        r_missing <= '0;
                    end
                end
                S_HEADER: begin
                    if (w_rd) begin
                        if (r_first) begin
                            r_tag   <= w_hdr_tag;
                            r_first <= 1'b0;
                        end else if (w_hdr_tag != r_tag) begin
                            r_tag_err <= 1'b1;
                        end
                        r_acc <= r_acc + 16'(w_hdr_size);
                        r_rem <= 16'(w_hdr_size);
                    end
                end
                S_PAYLOAD: begin
                    if (w_rd) begin
                        r_rem <= r_rem - 1'b1;
                        if (w_fwd_ok) begin
                            r_we   <= 1'b1;
                            r_data <= w_cur_data;
                            r_fwd  <= r_fwd + 1'b1;
                        end
                    end
                end
                S_PAD: begin
                    if (!ew_fifo_full) begin
                        r_rem <= r_rem - 1'b1;
                        if (w_fwd_ok) begin
                            r_we   <= 1'b1;
                            r_data <= '0;
                            r_fwd  <= r_fwd + 1'b1;
                        end
                    end
                end
                S_NEXT: begin
                    if (w_next_vld) begin
                        r_idx <= w_next_idx;
                        r_tmo <= '0;
                    end else begin
                        r_size <= (w_beats > MAXB) ? MAXB[11:0] : w_beats[11:0];
                        r_ovfl <= (w_beats > MAXB);
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign curr_ewfifo_wr = r_curr;
    assign ew_fifo_we     = r_we;
    assign ew_data        = r_data;
    assign ew_done        = r_done;
    assign ew_size        = r_size;
    assign ew_tag         = r_tag;
    assign ew_ovfl        = r_ovfl;
    assign ew_tag_error   = r_tag_err;
    assign ew_timeout     = r_timeout;
    assign ew_ch_missing  = r_missing;

endmodule

// File: tb/tb_rocfifo_merge_cntrl.sv
// Bench for rocfifo_merge_cntrl: queue-backed FWFT ROCFIFOs, event-level reference model,
// directed vector table, hand sequences (stall, HOLD), then randomized events.
`timescale 1ns/1ps
module tb_rocfifo_merge_cntrl;
    localparam int N    = 4;
    localparam int DB   = 32;
    localparam int TB   = 20;
    localparam int MAXB = 1020;
    localparam int RWT  = 240;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [N-1:0]      empty = '1;
    logic [N*DB-1:0]   data = '0;
    logic [N-1:0]      re;
    logic [N-1:0]      en = '0;
    logic              full = 1'b0;
    logic              axi = 1'b0;
    logic              curr, we, done, ovfl, terr, tout;
    logic [DB-1:0]     ewd;
    logic [11:0]       sz;
    logic [TB-1:0]     tag;
    logic [N-1:0]      miss;

    always #5 clk = ~clk;

    rocfifo_merge_cntrl #(.NROCFIFO(N), .DIGI_BITS(DB), .TAG_BITS(TB), .MAX_BEATS(MAXB),
                          .TIMEOUT(4096), .RESET_WAIT(RWT)) dut (
        .serdesclk(clk), .resetn_serdesclk(rstn),
        .rocfifo_empty(empty), .rocfifo_data(data), .rocfifo_re(re),
        .ch_enable(en), .ew_fifo_full(full), .axi_start_on_serdesclk(axi),
        .curr_ewfifo_wr(curr), .ew_fifo_we(we), .ew_data(ewd), .ew_done(done),
        .ew_size(sz), .ew_tag(tag), .ew_ovfl(ovfl), .ew_tag_error(terr),
        .ew_timeout(tout), .ew_ch_missing(miss));

    typedef struct packed {
        logic [N-1:0]           en;
        logic [N-1:0][11:0]     size;
        logic [N-1:0][TB-1:0]   tag;
        logic [N-1:0][11:0]     avail;
        int                     exp_wr;
        int                     exp_zero;
        logic [11:0]            exp_size;
        logic                   exp_ovfl;
        logic                   exp_terr;
        logic                   exp_tout;
        logic [N-1:0]           exp_miss;
        logic [TB-1:0]          exp_tag;
    } vec_t;

    logic [DB-1:0] fq [N][$];
    logic [DB-1:0] exp_q [$];
    logic [DB-1:0] got_q [$];
    int  nchk = 0, npass = 0;
    int  viol = 0, done_cnt = 0, re_cnt = 0, rel_cyc = 0, first_re = -1, evn = 0;
    bit  gaps = 1'b0, rnd_full = 1'b0, prev_full = 1'b0;
    logic [N-1:0] cur_en = '0;
    logic [N-1:0] re_s;
    // model results for the loaded event
    logic [11:0]   m_size;
    logic          m_ovfl, m_terr, m_tout, m_curr = 1'b1;
    logic [N-1:0]  m_miss;
    logic [TB-1:0] m_tag;
    int            m_zero;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (event %0d)", name, act, exp, evn);
    endtask

    // ROCFIFO emulation plus bus-protocol monitor
    always begin
        @(negedge clk);
        re_s = re;
        if (rstn) rel_cyc++;
        if (|re_s) begin
            re_cnt++;
            if (first_re < 0) first_re = rel_cyc;
        end
        if (|(re_s & ~cur_en) || |(re_s & empty) || $countones(re_s) > 1 || (|re_s && full)) viol++;
        if (we) begin
            got_q.push_back(ewd);
            if (prev_full) viol++;
        end
        if (done) done_cnt++;
        prev_full = full;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (re_s[i] && fq[i].size() > 0) void'(fq[i].pop_front());
            empty[i] = (fq[i].size() == 0) || (gaps && $urandom_range(0, 3) == 0);
            data[i*DB +: DB] = (fq[i].size() > 0) ? fq[i][0] : '0;
        end
    end

    function automatic vec_t mk(logic [N-1:0] e, logic [N-1:0][11:0] s, logic [N-1:0][TB-1:0] t,
                                logic [N-1:0][11:0] a, int wr, int z, int esz,
                                logic ov, logic te, logic to, logic [N-1:0] ms);
        vec_t v;
        v.en = e; v.size = s; v.tag = t; v.avail = a;
        v.exp_wr = wr; v.exp_zero = z; v.exp_size = 12'(esz);
        v.exp_ovfl = ov; v.exp_terr = te; v.exp_tout = to; v.exp_miss = ms; v.exp_tag = 20'h00123;
        return v;
    endfunction

    // Fill channel queues and derive the expected event from the rules
    task automatic load_ev(input vec_t v);
        int acc = 0;
        bit first = 1'b1;
        logic [DB-1:0] w;
        evn++;
        exp_q.delete(); got_q.delete();
        m_terr = 0; m_tout = 0; m_miss = '0; m_tag = '0; m_zero = 0;
        for (int ch = 0; ch < N; ch++) begin
            fq[ch].push_back({v.size[ch], v.tag[ch]});
            if (v.en[ch]) begin
                if (first) begin m_tag = v.tag[ch]; first = 1'b0; end
                else if (v.tag[ch] != m_tag) m_terr = 1'b1;
                acc += int'(v.size[ch]);
                for (int k = 0; k < int'(v.size[ch]); k++) begin
                    if (k < int'(v.avail[ch])) begin
                        w = {8'hA0 | 8'(ch), 8'(evn), 16'(k + 1)};
                        fq[ch].push_back(w);
                        exp_q.push_back(w);
                    end else begin
                        exp_q.push_back('0);
                        m_tout = 1'b1;
                        m_miss[ch] = 1'b1;
                    end
                end
            end
        end
        while (exp_q.size() > 2 * MAXB) void'(exp_q.pop_back());
        foreach (exp_q[i]) if (exp_q[i] == '0) m_zero++;
        m_size = 12'((acc / 2 > MAXB) ? MAXB : acc / 2);
        m_ovfl = (acc / 2 > MAXB);
        m_curr = ~m_curr;
        en = v.en;
        cur_en = v.en;
    endtask

    task automatic wait_check(input bit tm, input vec_t v, input int stall_at);
        int cyc = 0, scnt = 0, v0 = viol, d0 = done_cnt, nm = 0, left = 0;
        bit stalled = 1'b0, seen = 1'b0;
        while (!seen && cyc < 30000) begin
            @(posedge clk); #1; cyc++;
            if (scnt > 0) begin full = 1'b1; scnt--; end
            else if (!stalled && stall_at > 0 && got_q.size() >= stall_at) begin
                stalled = 1'b1; full = 1'b1; scnt = 9;
            end else full = rnd_full ? ($urandom_range(0, 5) == 0) : 1'b0;
            if (done) seen = 1'b1;
        end
        full = 1'b0;
        repeat (4) @(negedge clk);
        chk("done_seen", 32'(seen), 1);
        chk("n_writes", got_q.size(), tm ? v.exp_wr : exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) if (got_q[i] !== exp_q[i]) nm++;
        chk("word_order", nm, 0);
        nm = 0;
        foreach (got_q[i]) if (got_q[i] == '0) nm++;
        chk("zero_words", nm, tm ? v.exp_zero : m_zero);
        chk("ew_size", 32'(sz), 32'(tm ? v.exp_size : m_size));
        chk("ew_ovfl", 32'(ovfl), 32'(tm ? v.exp_ovfl : m_ovfl));
        chk("ew_tag_error", 32'(terr), 32'(tm ? v.exp_terr : m_terr));
        chk("ew_timeout", 32'(tout), 32'(tm ? v.exp_tout : m_tout));
        chk("ew_ch_missing", 32'(miss), 32'(tm ? v.exp_miss : m_miss));
        chk("ew_tag", 32'(tag), 32'(tm ? v.exp_tag : m_tag));
        chk("curr_ewfifo_wr", 32'(curr), 32'(m_curr));
        chk("done_pulses", done_cnt - d0, 1);
        chk("protocol", viol - v0, 0);
        for (int ch = 0; ch < N; ch++) begin
            if (v.en[ch]) left += fq[ch].size();
            fq[ch].delete();
        end
        chk("drained", left, 0);
    endtask

    task automatic release_ev();
        @(posedge clk); #1 axi = 1'b1;
        @(posedge clk); #1 axi = 1'b0;
    endtask

    vec_t tbl [6];
    vec_t rv;
    logic c0;
    int r0;

    initial begin
        tbl[0] = mk(4'hF, {4{12'd4}}, {4{20'h00123}}, {4{12'd4}}, 16, 0, 8, 0, 0, 0, 4'b0000);
        tbl[1] = mk(4'hF, {4{12'd4}}, {20'h00123, 20'h00124, 20'h00123, 20'h00123}, {4{12'd4}},
                    16, 0, 8, 0, 1, 0, 4'b0000);
        tbl[2] = mk(4'hF, {12'd0, 12'd0, 12'd0, 12'd2100}, {4{20'h00123}}, {12'd0, 12'd0, 12'd0, 12'd2100},
                    2040, 0, 1020, 1, 0, 0, 4'b0000);
        tbl[3] = mk(4'hF, {4{12'd8}}, {4{20'h00123}}, {12'd8, 12'd8, 12'd2, 12'd8}, 32, 6, 16, 0, 0, 1, 4'b0010);
        tbl[4] = mk(4'b0101, {4{12'd4}}, {4{20'h00123}}, {4{12'd4}}, 8, 0, 4, 0, 0, 0, 4'b0000);
        tbl[5] = mk(4'b0011, {12'd0, 12'd0, 12'd4, 12'd3}, {4{20'h00123}}, {12'd0, 12'd0, 12'd4, 12'd3},
                    7, 0, 3, 0, 0, 0, 4'b0000);

        // Reset state, with channel data already waiting
        load_ev(tbl[0]);
        repeat (3) @(negedge clk);
        chk("rst_curr", 32'(curr), 1);
        chk("rst_outs", {we, done, ovfl, terr, tout, sz, miss}, 0);
        chk("rst_tag", 32'(tag), 0);
        chk("rst_re", 32'(re), 0);
        @(posedge clk); #1 rstn = 1'b1;
        wait_check(1'b1, tbl[0], 0);
        chk("reset_wait", 32'(first_re >= RWT && first_re <= RWT + 10), 1);
        release_ev();

        for (int i = 1; i < 4; i++) begin
            load_ev(tbl[i]); wait_check(1'b1, tbl[i], 0); release_ev();
        end
        load_ev(tbl[5]); wait_check(1'b1, tbl[5], 0); release_ev();

        // Backpressure held 10 cycles mid-payload
        rv = mk(4'hF, {4{12'd8}}, {4{20'h00123}}, {4{12'd8}}, 32, 0, 16, 0, 0, 0, 4'b0000);
        load_ev(rv); wait_check(1'b0, rv, 5); release_ev();

        // Masked event, then next event must wait in HOLD for axi_start
        load_ev(tbl[4]); wait_check(1'b1, tbl[4], 0);
        c0 = curr;
        load_ev(tbl[0]);
        r0 = re_cnt;
        repeat (20) @(negedge clk);
        chk("hold_no_re", re_cnt - r0, 0);
        chk("hold_curr", 32'(curr), 32'(c0));
        release_ev();
        wait_check(1'b1, tbl[0], 0);
        release_ev();

        // Randomized events against the model
        gaps = 1'b1; rnd_full = 1'b1;
        for (int e = 0; e < 20; e++) begin
            rv = '0;
            rv.en = 4'($urandom_range(1, 15));
            for (int ch = 0; ch < N; ch++) begin
                rv.size[ch]  = 12'($urandom_range(0, 24));
                rv.avail[ch] = rv.size[ch];
                rv.tag[ch]   = ($urandom_range(0, 3) == 0) ? 20'($urandom) : 20'h0ABCD;
            end
            load_ev(rv);
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1 axi = 1'b1;
                @(posedge clk); #1 axi = 1'b0;
            end
            wait_check(1'b0, rv, 0);
            release_ev();
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
